// File: rtl/barrier_sprite_pkg.sv
// Shared types and constants for the barrier sprite: FSM states, palette,
// texture and drift direction.
package barrier_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPROACH,
        HITTABLE,
        DONE
    } barrier_state_t;

    typedef logic [1:0] pal_idx_t;

    // Horizontal drift: -1 left, 0 none, +1 right
    typedef logic signed [1:0] dir_t;

    localparam int unsigned SPRITE_H = 32;

    // Index order: 0 transparent, 1 red, 2 sky, 3 white
    localparam logic [3:0][23:0] PALETTE = {
        24'hFF_FF_FF,
        24'h8E_D8_ED,
        24'hFF_00_00,
        24'h00_00_00
    };

    // One 32-bit word per texel row, 2 bits per column; rows 3..6 are red
    localparam logic [7:0][31:0] TEXTURE = {
        32'h0000_0000,
        {4{32'h5555_5555}},
        {3{32'h0000_0000}}
    };

    function automatic pal_idx_t texel(input logic [2:0] row, input logic [3:0] col);
        return TEXTURE[row][{col, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/barrier_sprite_if.sv
// Pixel query bus: the pixel pipeline presents a coordinate and the sprite
// answers with its colour and coverage for that coordinate.
interface barrier_sprite_if;
    logic [15:0] i_x;
    logic [15:0] i_y;
    logic [7:0]  o_red;
    logic [7:0]  o_green;
    logic [7:0]  o_blue;
    logic        o_sprite_hit;

    modport master (
        output i_x, i_y,
        input  o_red, o_green, o_blue, o_sprite_hit
    );

    modport slave (
        input  i_x, i_y,
        output o_red, o_green, o_blue, o_sprite_hit
    );
endinterface

// File: rtl/barrier_sprite_vsync_tick.sv
// Frame tick generator: one-cycle pulse on the rising edge of v_sync.
module vsync_tick (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_v_sync,
    output logic o_tick
);
    logic v_sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) v_sync_q <= 1'b0;
        else       v_sync_q <= i_v_sync;
    end

    assign o_tick = i_v_sync & ~v_sync_q;
endmodule

// File: rtl/barrier_sprite.sv
// Pseudo-perspective barrier sprite for one lane: moves, scales, reports hittability.
// Optional hit flash enabled by defining BARRIER_HIT_FLASH_EN.
module barrier_sprite
    import barrier_pkg::*;
#(
    parameter dir_t        DIR          = 2'sd1,
    parameter int unsigned START_X      = 680,
    parameter int unsigned START_Y      = 360,
    parameter int unsigned STEP_X       = 10,
    parameter int unsigned STEP_Y       = 10,
    parameter int unsigned STAGE1_Y     = 440,
    parameter int unsigned STAGE2_Y     = 550,
    parameter int unsigned STAGE3_Y     = 620,
    parameter int unsigned HIT_Y        = 550,
    parameter int unsigned END_Y        = 720,
    parameter int unsigned BASE_SHIFT   = 2,
    parameter int unsigned FLASH_FRAMES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_v_sync,
    input  logic             i_active,
    input  logic             i_hit,
    barrier_sprite_if.slave  pix,
    output logic             o_in_position,
    output logic             o_done
);
    localparam int X_DELTA = int'(DIR) * int'(STEP_X);

    logic           tick;
    barrier_state_t state, state_n;
    logic [15:0]    x, y, x_n, y_n;
    logic           done_n;
    logic [16:0]    y_sum;
    logic signed [31:0] x_sum;
    logic [15:0]    x_step;
    logic [1:0]     stage;
    logic [2:0]     xshift;
    logic           flash_on;

    vsync_tick u_tick (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_v_sync (i_v_sync),
        .o_tick   (tick)
    );

    // Saturating horizontal step; the sum is formed wide enough to never wrap
    always_comb begin
        x_sum = $signed({16'b0, x}) + X_DELTA;
        if (x_sum < 0)              x_step = '0;
        else if (x_sum > 32'sd65535) x_step = '1;
        else                        x_step = x_sum[15:0];
        y_sum = {1'b0, y} + 17'(STEP_Y);
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        done_n  = 1'b0;
        if (!i_active) begin
            state_n = IDLE;
            x_n     = 16'(START_X);
            y_n     = 16'(START_Y);
        end else if (tick) begin
            unique case (state)
                IDLE: begin
                    state_n = APPROACH;
                    x_n     = x_step;
                    y_n     = y_sum[15:0];
                end
                APPROACH: begin
                    x_n = x_step;
                    y_n = y_sum[15:0];
                    if (y_sum >= 17'(HIT_Y)) state_n = HITTABLE;
                end
                HITTABLE: begin
                    x_n = x_step;
                    if (y_sum >= 17'(END_Y)) begin
                        y_n     = 16'(END_Y);
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        y_n = y_sum[15:0];
                    end
                end
                DONE: ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            x             <= 16'(START_X);
            y             <= 16'(START_Y);
            o_in_position <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state         <= state_n;
            x             <= x_n;
            y             <= y_n;
            o_in_position <= (state_n == HITTABLE);
            o_done        <= done_n;
        end
    end

`ifdef BARRIER_HIT_FLASH_EN
    logic [7:0] flash;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                              flash <= '0;
        else if (state_n == IDLE)               flash <= '0;
        else if (i_hit && state == HITTABLE)    flash <= 8'(FLASH_FRAMES);
        else if (tick && flash != '0)           flash <= flash - 8'd1;
    end

    assign flash_on = (flash != '0) && flash[1];
`else
    localparam int unsigned unused_flash_frames = FLASH_FRAMES;
    logic unused_hit;
    assign unused_hit = i_hit;
    assign flash_on   = 1'b0;
`endif

    // Stage follows the registered y directly, so it changes with y
    always_comb begin
        if (y >= 16'(STAGE3_Y))      stage = 2'd3;
        else if (y >= 16'(STAGE2_Y)) stage = 2'd2;
        else if (y >= 16'(STAGE1_Y)) stage = 2'd1;
        else                         stage = 2'd0;
        xshift = 3'(BASE_SHIFT) + {1'b0, stage};
    end

    logic [16:0] dx, dy;
    logic        in_win, visible;
    pal_idx_t    idx, idx_shown;
    logic [23:0] rgb;

    always_comb begin
        dx      = {1'b0, pix.i_x} - {1'b0, x};
        dy      = {1'b0, pix.i_y} - {1'b0, y};
        in_win  = (pix.i_x >= x) && (dx < (17'd16 << xshift)) &&
                  (pix.i_y >= y) && (dy < 17'(SPRITE_H));
        visible = (state == APPROACH) || (state == HITTABLE);
        idx     = texel(dy[4:2], 4'(dx >> xshift));
        idx_shown = (flash_on && idx == 2'd1) ? 2'd3 : idx;
        rgb     = (in_win && visible) ? PALETTE[idx_shown] : '0;
    end

    assign pix.o_red        = rgb[23:16];
    assign pix.o_green      = rgb[15:8];
    assign pix.o_blue       = rgb[7:0];
    assign pix.o_sprite_hit = in_win && visible && (idx != 2'd0);
endmodule

// File: tb/tb_barrier_sprite.sv
// Self-checking bench for barrier_sprite: directed literal checks plus a
// randomized run against a behavioural model of position, visibility and pixels.
module tb_barrier_sprite;
    localparam int START_X = 680, START_Y = 360, STEP_X = 10, STEP_Y = 10;
    localparam int HIT_Y = 550, END_Y = 720, DIR = 1, FLASH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v_sync = 1'b0, active = 1'b0, hit = 1'b0;
    logic inpos_main, done_main, inpos_sat, done_sat, inpos_px, done_px;
    int   n_checks = 0, n_fail = 0;
    logic done1, done2, ip1;

    always #5 clk = ~clk;

    barrier_sprite_if pix_main ();
    barrier_sprite_if pix_sat ();
    barrier_sprite_if pix_px ();

    barrier_sprite dut (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_active(active), .i_hit(hit),
        .pix(pix_main.slave), .o_in_position(inpos_main), .o_done(done_main)
    );

    barrier_sprite #(.DIR(-2'sd1), .START_X(15), .STEP_X(10)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_active(active), .i_hit(hit),
        .pix(pix_sat.slave), .o_in_position(inpos_sat), .o_done(done_sat)
    );

    barrier_sprite #(.STEP_X(0), .STEP_Y(0)) dut_px (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_active(active), .i_hit(hit),
        .pix(pix_px.slave), .o_in_position(inpos_px), .o_done(done_px)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The run is described by the number of steps taken since spawn and
    // whether the end line has been reached.
    int m_n = 0, m_flash = 0;
    bit m_fin = 0, m_vq = 0, m_done = 0;

    function automatic int m_y();
        return m_fin ? END_Y : START_Y + m_n * STEP_Y;
    endfunction

    function automatic int m_x();
        int v;
        v = START_X + DIR * STEP_X * m_n;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        return v;
    endfunction

    function automatic bit m_vis();
        return (m_n > 0) && !m_fin;
    endfunction

    function automatic bit m_inpos();
        return m_vis() && (m_y() >= HIT_Y);
    endfunction

    function automatic int m_width();
        int y, st;
        y = m_y();
        st = (y >= 620) ? 3 : (y >= 550) ? 2 : (y >= 440) ? 1 : 0;
        return 16 << (2 + st);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_fin = 0; m_vq = 0; m_done = 0; m_flash = 0;
        end else begin
            bit tk;
            tk = v_sync && !m_vq;
            m_vq = v_sync;
            m_done = 0;
            if (!active) begin
                m_n = 0; m_fin = 0; m_flash = 0;
            end else begin
`ifdef BARRIER_HIT_FLASH_EN
                if (hit && m_inpos()) m_flash = FLASH;
                else if (tk && m_flash != 0) m_flash--;
`endif
                if (tk && !m_fin) begin
                    m_n++;
                    if (START_Y + m_n * STEP_Y >= END_Y) begin
                        m_fin = 1; m_done = 1;
                    end
                end
            end
        end
    end

    // Compare process: main instance against the model every cycle
    always @(negedge clk) begin
        if (!rst) begin
            int ix, iy, x, y, row;
            bit win, eh;
            logic [23:0] erg;
            ix = int'(pix_main.i_x); iy = int'(pix_main.i_y);
            x = m_x(); y = m_y();
            win = m_vis() && ix >= x && ix < x + m_width() && iy >= y && iy < y + 32;
            row = (iy - y) / 4;
            eh = win && row >= 3 && row <= 6;
            erg = 24'h0;
            if (eh) erg = (m_flash != 0 && m_flash[1]) ? 24'hFFFFFF : 24'hFF0000;
            check("in_position", 32'(inpos_main), 32'(m_inpos()));
            check("done", 32'(done_main), 32'(m_done));
            check("sprite_hit", 32'(pix_main.o_sprite_hit), 32'(eh));
            check("rgb", 32'({pix_main.o_red, pix_main.o_green, pix_main.o_blue}), 32'(erg));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_tick();
        v_sync = 1'b1;
        @(posedge clk); #1;
        done1 = done_main; ip1 = inpos_main;
        v_sync = 1'b0;
        @(posedge clk); #1;
        done2 = done_main;
    endtask

    task automatic probe(input int which, input int ix, input int iy, input bit eh,
                         input bit chk_rgb, input logic [23:0] erg, input string nm);
        logic sh;
        logic [23:0] rgb;
        @(posedge clk); #1;
        case (which)
            0: begin pix_main.i_x = 16'(ix); pix_main.i_y = 16'(iy); end
            1: begin pix_sat.i_x = 16'(ix);  pix_sat.i_y = 16'(iy);  end
            default: begin pix_px.i_x = 16'(ix); pix_px.i_y = 16'(iy); end
        endcase
        #1;
        case (which)
            0: begin sh = pix_main.o_sprite_hit; rgb = {pix_main.o_red, pix_main.o_green, pix_main.o_blue}; end
            1: begin sh = pix_sat.o_sprite_hit;  rgb = {pix_sat.o_red, pix_sat.o_green, pix_sat.o_blue}; end
            default: begin sh = pix_px.o_sprite_hit; rgb = {pix_px.o_red, pix_px.o_green, pix_px.o_blue}; end
        endcase
        check({nm, "_hit"}, 32'(sh), 32'(eh));
        if (chk_rgb) check({nm, "_rgb"}, 32'(rgb), 32'(erg));
    endtask

    initial begin
        pix_main.i_x = 16'd680; pix_main.i_y = 16'd372;
        pix_sat.i_x = '0; pix_sat.i_y = '0;
        pix_px.i_x = '0;  pix_px.i_y = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_in_position", 32'(inpos_main), 32'd0);
        check("reset_done", 32'(done_main), 32'd0);
        check("reset_sprite_hit", 32'(pix_main.o_sprite_hit), 32'd0);
        check("reset_rgb", 32'({pix_main.o_red, pix_main.o_green, pix_main.o_blue}), 32'd0);

        active = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 36; i++) begin
            do_tick();
            if (i == 1) begin
                probe(0, 690, 381, 1'b0, 1'b0, 24'h0, "t1_row2");
                probe(0, 690, 382, 1'b1, 1'b1, 24'hFF0000, "t1_row3");
                probe(0, 689, 382, 1'b0, 1'b0, 24'h0, "t1_left");
                probe(1, 5, 382, 1'b1, 1'b0, 24'h0, "sat_t1_in");
                probe(1, 4, 382, 1'b0, 1'b0, 24'h0, "sat_t1_out");
                probe(2, 680, 372, 1'b1, 1'b1, 24'hFF0000, "px_red");
                probe(2, 680, 360, 1'b0, 1'b1, 24'h0, "px_transparent");
                probe(2, 744, 372, 1'b0, 1'b1, 24'h0, "px_outside");
                probe(2, 743, 372, 1'b1, 1'b0, 24'h0, "px_last_col");
            end
            if (i == 2) probe(1, 0, 392, 1'b1, 1'b0, 24'h0, "sat_t2_zero");
            if (i == 3) probe(1, 0, 402, 1'b1, 1'b0, 24'h0, "sat_t3_zero");
            if (i == 18) check("t18_in_position", 32'(ip1), 32'd0);
            if (i == 19) begin
                check("t19_in_position", 32'(ip1), 32'd1);
                probe(0, 870, 562, 1'b1, 1'b1, 24'hFF0000, "t19_left");
                probe(0, 1125, 562, 1'b1, 1'b0, 24'h0, "t19_w256_in");
                probe(0, 1126, 562, 1'b0, 1'b0, 24'h0, "t19_w256_out");
            end
`ifdef BARRIER_HIT_FLASH_EN
            if (i == 20) begin
                hit = 1'b1;
                @(posedge clk); #1;
                hit = 1'b0;
                probe(0, 880, 572, 1'b1, 1'b1, 24'hFF0000, "flash16");
            end
            if (i == 21) probe(0, 890, 582, 1'b1, 1'b1, 24'hFFFFFF, "flash15");
`endif
            if (i < 36) check("pre_end_done", 32'(done1), 32'd0);
        end
        check("end_done_pulse", 32'(done1), 32'd1);
        check("end_done_cleared", 32'(done2), 32'd0);
        probe(0, 1040, 732, 1'b0, 1'b1, 24'h0, "after_done");
        check("after_done_in_position", 32'(inpos_main), 32'd0);

        // Abort from DONE, run to y = 450, abort again
        active = 1'b0;
        @(posedge clk); #1;
        active = 1'b1;
        for (int i = 0; i < 9; i++) do_tick();
        active = 1'b0;
        @(posedge clk); #1;
        check("abort_in_position", 32'(inpos_main), 32'd0);
        check("abort_done", 32'(done_main), 32'd0);
        active = 1'b1;
        do_tick();
        probe(0, 690, 382, 1'b1, 1'b1, 24'hFF0000, "respawn");

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (c == 2200) rst = 1'b1;
            else rst = 1'b0;
            v_sync = 1'($urandom_range(0, 1));
            active = ($urandom_range(0, 299) != 0);
            hit    = ($urandom_range(0, 7) == 0);
            begin
                int w, ix, iy;
                w = m_width();
                case ($urandom_range(0, 5))
                    0: ix = m_x() - 1;
                    1: ix = m_x();
                    2: ix = m_x() + w - 1;
                    3: ix = m_x() + w;
                    default: ix = m_x() + int'($urandom_range(0, w - 1));
                endcase
                case ($urandom_range(0, 8))
                    0: iy = m_y() - 1;
                    1: iy = m_y();
                    2: iy = m_y() + 11;
                    3: iy = m_y() + 12;
                    4: iy = m_y() + 27;
                    5: iy = m_y() + 28;
                    6: iy = m_y() + 31;
                    7: iy = m_y() + 32;
                    default: iy = m_y() + int'($urandom_range(0, 31));
                endcase
                pix_main.i_x = 16'(ix);
                pix_main.i_y = 16'(iy);
            end
        end
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
